esfa_op_sequencer: RTL and testbench
====================================

# esfa_op_sequencer

Command sequencer that sits directly upstream of the array of `MemoryCell` instances. It accepts one host operation at a time over a valid/ready port and translates it into one or two selector cycles broadcast to all cells. It reduces the cells' `new_bool`/`new_result_value`/`new_context` vectors into a single response returned over a valid/ready port. INSERT and CONGRUE_UP are two-phase: phase 1 finds a free cell, phase 2 issues the write.

## Interface
- `N_CELLS`, 8, number of cells; each cell's `handle` = its position, 0..N_CELLS-1.
- `W`, 8, data/handle/code/rank width.
- `clk` in 1: the single clock; all logic on posedge.
- `reset` in 1: synchronous, active-low.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_op` in 3: 0 INSERT, 1 LOOKUP, 2 ENCODE, 3 ENRANK, 4 CONGRUE_UP, 5 CONGRUE_DOWN; 6–7 illegal.
- `cmd_handle`, `cmd_index`, `cmd_value`, `cmd_code`, `cmd_rank` in W: operands.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_hit` out 1, `rsp_handle` out W, `rsp_value` out W, `rsp_context` out W: response fields.
- `selector` out 8: broadcast to cells; holds SEL_HOLD (8) whenever no operation is being issued.
- `queried_handle`, `available_handle`, `inserted_index`, `inserted_value`, `given_code`, `given_rank` out W: broadcast to cells.
- `is_available_handle`, `is_given_code`, `is_given_rank` out 1: broadcast to cells.
- `cell_bool` in N_CELLS: one bit per cell.
- `cell_result`, `cell_context` in N_CELLS*W: per-cell result and context; cell i occupies bits [i*W +: W].

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1.
  - ISSUE: selector driven for exactly 1 cycle.
  - CAPTURE: selector=HOLD; cell outputs are valid and reduced.
  - ISSUE2 / CAPTURE2: second phase of two-phase ops.
  - RESP: `rsp_valid`=1 until `rsp_ready`.
- Transitions:
  - IDLE→ISSUE on cmd_valid&cmd_ready with a legal op.
  - IDLE→RESP on cmd_valid&cmd_ready with an illegal op; response has `rsp_hit`=0 and all other fields 0.
  - ISSUE→CAPTURE.
  - CAPTURE→RESP for single-phase ops.
  - CAPTURE→ISSUE2 for two-phase ops when a free cell exists; CAPTURE→RESP when none exists.
  - ISSUE2→CAPTURE2→RESP.
  - RESP→IDLE on `rsp_ready`.
- Operand registers are captured on accept and held until return to IDLE.
- Per-op issue:
  - INSERT:
    - Phase 1: selector 5.
    - Free handle = lowest i with `cell_bool[i]`; none → `rsp_hit`=0, `rsp_handle`=0.
    - Phase 2: selector 0, `available_handle`=free, `is_available_handle`=1, `inserted_index`=cmd_index, `inserted_value`=cmd_value.
    - Response: `rsp_hit`=1, `rsp_handle`=free.
  - LOOKUP:
    - Drive selector 1, `inserted_index`=cmd_index, `given_code`=cmd_code, `is_given_code`=1.
    - Winner = hitting cell with the largest `cell_context` (rank); ties go to the lowest index.
    - Response: `rsp_value`/`rsp_context` from the winner, `rsp_handle`=winner index.
  - ENCODE / ENRANK:
    - Drive selector 2 / 6 with `queried_handle`=cmd_handle.
    - Response from the lowest-index hit.
  - CONGRUE_UP:
    - Phase 1 as INSERT.
    - Phase 2: selector 3, `given_code`=cmd_code, `given_rank`=cmd_rank, `is_given_code`=`is_given_rank`=1, `available_handle`=free, `is_available_handle`=1.
    - Response: `rsp_hit`=1, `rsp_handle`=free.
  - CONGRUE_DOWN:
    - Drive selector 4, `queried_handle`=cmd_handle, `given_code`=cmd_code, `is_given_code`=1.
    - Response: `rsp_hit`=OR of `cell_bool`.
- Selector is never held in a write op for more than 1 cycle, and HOLD always follows. This keeps each cell's single-write guard re-armed between ops.
- All `is_*` strobes are 0 outside ISSUE/ISSUE2.
- Widths: handle index is truncated or zero-extended to W; there is no arithmetic on data paths.

## Timing
- Reset values:
  - `selector`=8.
  - `cmd_ready`=1.
  - All other outputs 0.
  - State IDLE.
- Reset mid-operation aborts to IDLE with no response. A cell write already committed at a prior edge stays committed.
- All outputs are registered.
- Latency, accept edge to `rsp_valid` high:
  - Single-phase ops: 3 cycles.
  - Two-phase ops: 5 cycles.
  - Two-phase op with no free cell: 3 cycles.
  - Illegal op: 1 cycle.
- `cmd_ready` is 0 from the cycle after accept until the cycle after the response handshake.
- Response fields are stable while `rsp_valid`=1 and `rsp_ready`=0.
- A response handshake at edge t gives `cmd_ready`=1 in cycle t+1. There is no command/response overlap.

## Configuration
- `ESFA_SEQ_HIT_COUNT_EN`:
  - Defined: adds output `rsp_count` (W). It holds the popcount of `cell_bool` at the final CAPTURE, or 0 for illegal ops, and is registered with the other response fields.
  - Undefined: the port and popcount logic are absent. All other behaviour is identical.

## Structure
- Package `esfa_pkg`:
  - Selector constants SEL_UPDATE=0 … SEL_ENRANK=6, SEL_HOLD=8.
  - Host opcode enum.
  - FSM state enum.
  - Shared by cells and sequencer.
- Sub-module `esfa_hit_reducer`:
  - Combinational, parameterised by N_CELLS/W.
  - Outputs: any-hit, lowest-index hit, max-context hit index, and optional popcount.

## Test plan
- Reset, then INSERT index=3 value=0x55 into empty array → `rsp_hit`=1, `rsp_handle`=0, latency 5, selector sequence 5,8,0,8.
- 8 INSERTs then a 9th → 9th returns `rsp_hit`=0 at latency 3; selector never shows 0 for that command.
- Two cells matching LOOKUP index=3 code in range, ranks 1 and 2 → response has value of the rank-2 cell, `rsp_context`=2.
- ENCODE `cmd_handle`=9 → `rsp_hit`=0; ENCODE of a defined handle 2 → `rsp_hit`=1, `rsp_handle`=2.
- Hold `rsp_ready`=0 for 4 cycles → fields stable, `cmd_ready`=0 throughout; `cmd_ready`=1 the cycle after handshake.
- Assert reset in CAPTURE2 of CONGRUE_UP → next cycle `selector`=8, `rsp_valid`=0, `cmd_ready`=1.

Source files
------------

// File: rtl/esfa_pkg.sv
// Shared selector codes, host opcodes and sequencer states for the ESFA cell array.
package esfa_pkg;

    localparam logic [7:0] SEL_UPDATE       = 8'd0;
    localparam logic [7:0] SEL_LOOKUP       = 8'd1;
    localparam logic [7:0] SEL_ENCODE       = 8'd2;
    localparam logic [7:0] SEL_CONGRUE_UP   = 8'd3;
    localparam logic [7:0] SEL_CONGRUE_DOWN = 8'd4;
    localparam logic [7:0] SEL_AVAILABLE    = 8'd5;
    localparam logic [7:0] SEL_ENRANK       = 8'd6;
    localparam logic [7:0] SEL_HOLD         = 8'd8;

    typedef enum logic [2:0] {
        OP_INSERT       = 3'd0,
        OP_LOOKUP       = 3'd1,
        OP_ENCODE       = 3'd2,
        OP_ENRANK       = 3'd3,
        OP_CONGRUE_UP   = 3'd4,
        OP_CONGRUE_DOWN = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_ISSUE2,
        ST_CAPTURE2,
        ST_RESP
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'd5;
    endfunction

    // Ops that must locate a free cell before they can write.
    function automatic logic is_two_phase(input logic [2:0] op);
        return (op == OP_INSERT) || (op == OP_CONGRUE_UP);
    endfunction

endpackage

// File: rtl/esfa_op_sequencer_if.sv
// Host command/response port of the op sequencer.
// ESFA_SEQ_HIT_COUNT_EN adds the rsp_count field.
interface esfa_op_sequencer_if #(parameter int W = 8);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_handle;
    logic [W-1:0] cmd_index;
    logic [W-1:0] cmd_value;
    logic [W-1:0] cmd_code;
    logic [W-1:0] cmd_rank;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_hit;
    logic [W-1:0] rsp_handle;
    logic [W-1:0] rsp_value;
    logic [W-1:0] rsp_context;
`ifdef ESFA_SEQ_HIT_COUNT_EN
    logic [W-1:0] rsp_count;

    modport master (output cmd_valid, cmd_op, cmd_handle, cmd_index, cmd_value, cmd_code, cmd_rank,
                    output rsp_ready, input cmd_ready, rsp_valid, rsp_hit, rsp_handle, rsp_value,
                    input rsp_context, rsp_count);
    modport slave  (input cmd_valid, cmd_op, cmd_handle, cmd_index, cmd_value, cmd_code, cmd_rank,
                    input rsp_ready, output cmd_ready, rsp_valid, rsp_hit, rsp_handle, rsp_value,
                    output rsp_context, rsp_count);
`else
    modport master (output cmd_valid, cmd_op, cmd_handle, cmd_index, cmd_value, cmd_code, cmd_rank,
                    output rsp_ready, input cmd_ready, rsp_valid, rsp_hit, rsp_handle, rsp_value,
                    input rsp_context);
    modport slave  (input cmd_valid, cmd_op, cmd_handle, cmd_index, cmd_value, cmd_code, cmd_rank,
                    input rsp_ready, output cmd_ready, rsp_valid, rsp_hit, rsp_handle, rsp_value,
                    output rsp_context);
`endif
endinterface

// File: rtl/esfa_hit_reducer.sv
// Combinational reduction of per-cell hit bits: any, lowest index, highest-context index.
// ESFA_SEQ_HIT_COUNT_EN adds the hit popcount.
module esfa_hit_reducer #(
    parameter int N_CELLS = 8,
    parameter int W       = 8,
    parameter int IW      = (N_CELLS > 1) ? $clog2(N_CELLS) : 1
) (
    input  logic [N_CELLS-1:0]   cell_bool,
    input  logic [N_CELLS*W-1:0] cell_context,
    output logic                 any_hit,
    output logic [IW-1:0]        low_idx,
    output logic [IW-1:0]        max_idx
`ifdef ESFA_SEQ_HIT_COUNT_EN
    ,
    output logic [W-1:0]         hit_count
`endif
);

    logic [W-1:0] best_ctx;
    logic         found;

    always_comb begin
        any_hit  = |cell_bool;
        low_idx  = '0;
        max_idx  = '0;
        best_ctx = '0;
        found    = 1'b0;
        for (int i = N_CELLS - 1; i >= 0; i--) begin
            if (cell_bool[i]) low_idx = IW'(i);
        end
        // Strict compare keeps the lowest index on equal ranks.
        for (int i = 0; i < N_CELLS; i++) begin
            if (cell_bool[i] && (!found || (cell_context[i*W +: W] > best_ctx))) begin
                found    = 1'b1;
                best_ctx = cell_context[i*W +: W];
                max_idx  = IW'(i);
            end
        end
    end

`ifdef ESFA_SEQ_HIT_COUNT_EN
    always_comb begin
        hit_count = '0;
        for (int i = 0; i < N_CELLS; i++) hit_count = hit_count + W'(cell_bool[i]);
    end
`endif

endmodule

// File: rtl/esfa_op_sequencer.sv
// Host-op to cell-selector sequencer with hit reduction; all outputs registered.
// ESFA_SEQ_HIT_COUNT_EN adds rsp_count (hit popcount at the final capture).
//   state    | meaning
//   IDLE     | cmd_ready=1, waiting for a command
//   ISSUE    | phase-1 selector driven for one cycle
//   CAPTURE  | selector HOLD, cell outputs reduced
//   ISSUE2   | phase-2 write selector (INSERT / CONGRUE_UP)
//   CAPTURE2 | selector HOLD after the write
//   RESP     | rsp_valid=1 until rsp_ready
module esfa_op_sequencer
    import esfa_pkg::*;
#(
    parameter int N_CELLS = 8,
    parameter int W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    esfa_op_sequencer_if.slave   host,
    output logic [7:0]           selector,
    output logic [W-1:0]         queried_handle,
    output logic [W-1:0]         available_handle,
    output logic [W-1:0]         inserted_index,
    output logic [W-1:0]         inserted_value,
    output logic [W-1:0]         given_code,
    output logic [W-1:0]         given_rank,
    output logic                 is_available_handle,
    output logic                 is_given_code,
    output logic                 is_given_rank,
    input  logic [N_CELLS-1:0]   cell_bool,
    input  logic [N_CELLS*W-1:0] cell_result,
    input  logic [N_CELLS*W-1:0] cell_context
);

    localparam int IW = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;

    state_e       state, state_next;
    logic [2:0]   op_q;
    logic [W-1:0] index_q, value_q, code_q, rank_q, free_q;
    logic         any_hit;
    logic [IW-1:0] low_idx, max_idx, pick_idx;

    logic         cmd_ready_q, rsp_valid_q, rsp_hit_q, rsp_hit_d;
    logic [W-1:0] rsp_handle_q, rsp_value_q, rsp_context_q;
    logic [W-1:0] rsp_handle_d, rsp_value_d, rsp_context_d;
    logic [7:0]   sel_d;
    logic [W-1:0] qh_d, ah_d, ii_d, iv_d, gc_d, gr_d;
    logic         iah_d, igc_d, igr_d;

`ifdef ESFA_SEQ_HIT_COUNT_EN
    logic [W-1:0] hit_count, rsp_count_q, rsp_count_d;
    assign host.rsp_count = rsp_count_q;
`endif

    esfa_hit_reducer #(.N_CELLS(N_CELLS), .W(W), .IW(IW)) u_reducer (
        .cell_bool    (cell_bool),
        .cell_context (cell_context),
        .any_hit      (any_hit),
        .low_idx      (low_idx),
        .max_idx      (max_idx)
`ifdef ESFA_SEQ_HIT_COUNT_EN
        ,
        .hit_count    (hit_count)
`endif
    );

    assign pick_idx         = (op_q == OP_LOOKUP) ? max_idx : low_idx;
    assign host.cmd_ready   = cmd_ready_q;
    assign host.rsp_valid   = rsp_valid_q;
    assign host.rsp_hit     = rsp_hit_q;
    assign host.rsp_handle  = rsp_handle_q;
    assign host.rsp_value   = rsp_value_q;
    assign host.rsp_context = rsp_context_q;

    always_comb begin
        state_next    = state;
        rsp_hit_d     = rsp_hit_q;
        rsp_handle_d  = rsp_handle_q;
        rsp_value_d   = rsp_value_q;
        rsp_context_d = rsp_context_q;
        sel_d = SEL_HOLD;
        qh_d  = '0;
        ah_d  = '0;
        ii_d  = '0;
        iv_d  = '0;
        gc_d  = '0;
        gr_d  = '0;
        iah_d = 1'b0;
        igc_d = 1'b0;
        igr_d = 1'b0;

        case (state)
            ST_IDLE: begin
                if (host.cmd_valid) begin
                    if (op_legal(host.cmd_op)) begin
                        state_next = ST_ISSUE;
                    end else begin
                        state_next    = ST_RESP;
                        rsp_hit_d     = 1'b0;
                        rsp_handle_d  = '0;
                        rsp_value_d   = '0;
                        rsp_context_d = '0;
                    end
                end
            end
            ST_ISSUE: state_next = ST_CAPTURE;
            ST_CAPTURE: begin
                if (is_two_phase(op_q) && any_hit) begin
                    state_next = ST_ISSUE2;
                end else begin
                    state_next    = ST_RESP;
                    rsp_hit_d     = any_hit;
                    rsp_handle_d  = '0;
                    rsp_value_d   = '0;
                    rsp_context_d = '0;
                    if (any_hit) begin
                        rsp_handle_d  = W'(pick_idx);
                        rsp_value_d   = cell_result[pick_idx*W +: W];
                        rsp_context_d = cell_context[pick_idx*W +: W];
                    end
                end
            end
            ST_ISSUE2: state_next = ST_CAPTURE2;
            ST_CAPTURE2: begin
                state_next    = ST_RESP;
                rsp_hit_d     = 1'b1;
                rsp_handle_d  = free_q;
                rsp_value_d   = '0;
                rsp_context_d = '0;
            end
            ST_RESP: if (host.rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        // ISSUE is only entered from IDLE, so phase 1 reads the live command.
        if (state_next == ST_ISSUE) begin
            case (host.cmd_op)
                OP_INSERT, OP_CONGRUE_UP: sel_d = SEL_AVAILABLE;
                OP_LOOKUP: begin
                    sel_d = SEL_LOOKUP;
                    ii_d  = host.cmd_index;
                    gc_d  = host.cmd_code;
                    igc_d = 1'b1;
                end
                OP_ENCODE: begin
                    sel_d = SEL_ENCODE;
                    qh_d  = host.cmd_handle;
                end
                OP_ENRANK: begin
                    sel_d = SEL_ENRANK;
                    qh_d  = host.cmd_handle;
                end
                OP_CONGRUE_DOWN: begin
                    sel_d = SEL_CONGRUE_DOWN;
                    qh_d  = host.cmd_handle;
                    gc_d  = host.cmd_code;
                    igc_d = 1'b1;
                end
                default: sel_d = SEL_HOLD;
            endcase
        end else if (state_next == ST_ISSUE2) begin
            ah_d  = W'(low_idx);
            iah_d = 1'b1;
            if (op_q == OP_INSERT) begin
                sel_d = SEL_UPDATE;
                ii_d  = index_q;
                iv_d  = value_q;
            end else begin
                sel_d = SEL_CONGRUE_UP;
                gc_d  = code_q;
                gr_d  = rank_q;
                igc_d = 1'b1;
                igr_d = 1'b1;
            end
        end
    end

`ifdef ESFA_SEQ_HIT_COUNT_EN
    always_comb begin
        rsp_count_d = rsp_count_q;
        if (state_next == ST_RESP && state != ST_RESP)
            rsp_count_d = (state == ST_IDLE) ? '0 : hit_count;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state               <= ST_IDLE;
            op_q                <= '0;
            index_q             <= '0;
            value_q             <= '0;
            code_q              <= '0;
            rank_q              <= '0;
            free_q              <= '0;
            cmd_ready_q         <= 1'b1;
            rsp_valid_q         <= 1'b0;
            rsp_hit_q           <= 1'b0;
            rsp_handle_q        <= '0;
            rsp_value_q         <= '0;
            rsp_context_q       <= '0;
            selector            <= SEL_HOLD;
            queried_handle      <= '0;
            available_handle    <= '0;
            inserted_index      <= '0;
            inserted_value      <= '0;
            given_code          <= '0;
            given_rank          <= '0;
            is_available_handle <= 1'b0;
            is_given_code       <= 1'b0;
            is_given_rank       <= 1'b0;
`ifdef ESFA_SEQ_HIT_COUNT_EN
            rsp_count_q         <= '0;
`endif
        end else begin
            state               <= state_next;
            cmd_ready_q         <= (state_next == ST_IDLE);
            rsp_valid_q         <= (state_next == ST_RESP);
            rsp_hit_q           <= rsp_hit_d;
            rsp_handle_q        <= rsp_handle_d;
            rsp_value_q         <= rsp_value_d;
            rsp_context_q       <= rsp_context_d;
            selector            <= sel_d;
            queried_handle      <= qh_d;
            available_handle    <= ah_d;
            inserted_index      <= ii_d;
            inserted_value      <= iv_d;
            given_code          <= gc_d;
            given_rank          <= gr_d;
            is_available_handle <= iah_d;
            is_given_code       <= igc_d;
            is_given_rank       <= igr_d;
`ifdef ESFA_SEQ_HIT_COUNT_EN
            rsp_count_q         <= rsp_count_d;
`endif
            if (state == ST_IDLE && host.cmd_valid) begin
                op_q    <= host.cmd_op;
                index_q <= host.cmd_index;
                value_q <= host.cmd_value;
                code_q  <= host.cmd_code;
                rank_q  <= host.cmd_rank;
            end
            if (state == ST_CAPTURE) free_q <= W'(low_idx);
        end
    end

endmodule

// File: tb/tb_esfa_op_sequencer.sv
// Directed bench for esfa_op_sequencer; cell outputs are driven as static vectors per command.
module tb_esfa_op_sequencer;
    import esfa_pkg::*;

    localparam int N = 8;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    esfa_op_sequencer_if #(.W(W)) host();

    logic [7:0]   selector;
    logic [W-1:0] queried_handle, available_handle, inserted_index, inserted_value, given_code, given_rank;
    logic         is_available_handle, is_given_code, is_given_rank;
    logic [N-1:0] cell_bool;
    logic [N*W-1:0] cell_result, cell_context;

    esfa_op_sequencer #(.N_CELLS(N), .W(W)) dut (
        .clk(clk), .reset(reset), .host(host),
        .selector(selector), .queried_handle(queried_handle), .available_handle(available_handle),
        .inserted_index(inserted_index), .inserted_value(inserted_value),
        .given_code(given_code), .given_rank(given_rank),
        .is_available_handle(is_available_handle), .is_given_code(is_given_code),
        .is_given_rank(is_given_rank),
        .cell_bool(cell_bool), .cell_result(cell_result), .cell_context(cell_context)
    );

    int tests = 0;
    int fails = 0;
    int lat;
    logic [31:0] sel_pack;
    logic strobe_bad, cr_bad;
    logic [W-1:0] l_qh, l_ah, l_ii, l_iv, l_gc, l_gr;
    logic l_iah, l_igc, l_igr;

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] h, input logic [7:0] idx,
                            input logic [7:0] val, input logic [7:0] code, input logic [7:0] rank);
        host.cmd_valid = 1'b1; host.cmd_op = op; host.cmd_handle = h; host.cmd_index = idx;
        host.cmd_value = val; host.cmd_code = code; host.cmd_rank = rank;
        @(posedge clk); #1;
        host.cmd_valid = 1'b0;
    endtask

    // Logs selector history and the last non-HOLD broadcast until rsp_valid.
    task automatic wait_rsp();
        lat = 1; sel_pack = '0; strobe_bad = 1'b0; cr_bad = 1'b0;
        l_qh = '0; l_ah = '0; l_ii = '0; l_iv = '0; l_gc = '0; l_gr = '0;
        l_iah = 1'b0; l_igc = 1'b0; l_igr = 1'b0;
        while (host.rsp_valid !== 1'b1 && lat <= 20) begin
            sel_pack = {sel_pack[23:0], selector};
            if (selector != SEL_HOLD) begin
                l_qh = queried_handle; l_ah = available_handle; l_ii = inserted_index;
                l_iv = inserted_value; l_gc = given_code; l_gr = given_rank;
                l_iah = is_available_handle; l_igc = is_given_code; l_igr = is_given_rank;
            end else if (is_available_handle || is_given_code || is_given_rank) begin
                strobe_bad = 1'b1;
            end
            if (host.cmd_ready !== 1'b0) cr_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat > 20) begin fails++; $display("FAIL rsp_timeout: got no rsp_valid within %0d cycles", lat); end
    endtask

    task automatic finish_rsp();
        host.rsp_ready = 1'b1;
        @(posedge clk); #1;
        host.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (selector !== 8'd8) begin fails++; $display("FAIL reset_sel: got %0d want 8", selector); end
        tests++; if (host.cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b want 1", host.cmd_ready); end
        tests++; if (host.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", host.rsp_valid); end
        tests++; if ({is_available_handle, is_given_code, is_given_rank} !== 3'b000) begin
            fails++; $display("FAIL reset_strobes: got %b want 000", {is_available_handle, is_given_code, is_given_rank}); end
        tests++; if ({host.rsp_hit, host.rsp_handle, inserted_index} !== 17'd0) begin
            fails++; $display("FAIL reset_fields: got %0h want 0", {host.rsp_hit, host.rsp_handle, inserted_index}); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_insert_empty();
        cell_bool = 8'hFF;
        send_cmd(OP_INSERT, 8'd0, 8'd3, 8'h55, 8'd0, 8'd0);
        wait_rsp();
        tests++; if (lat != 5) begin fails++; $display("FAIL insert_latency: got %0d want 5", lat); end
        tests++; if (sel_pack !== 32'h05080008) begin fails++; $display("FAIL insert_selseq: got %h want 05080008", sel_pack); end
        tests++; if (host.rsp_hit !== 1'b1 || host.rsp_handle !== 8'd0) begin
            fails++; $display("FAIL insert_rsp: got hit=%b handle=%0d want hit=1 handle=0", host.rsp_hit, host.rsp_handle); end
        tests++; if ({l_iah, l_ah, l_ii, l_iv} !== {1'b1, 8'd0, 8'd3, 8'h55}) begin
            fails++; $display("FAIL insert_bcast: got iah=%b ah=%0d ii=%0d iv=%h want 1 0 3 55", l_iah, l_ah, l_ii, l_iv); end
        tests++; if (strobe_bad !== 1'b0 || cr_bad !== 1'b0) begin
            fails++; $display("FAIL insert_idle_sig: got strobe_bad=%b cr_bad=%b want 0 0", strobe_bad, cr_bad); end
        finish_rsp();
    endtask

    task automatic test_fill();
        logic [7:0] occ;
        occ = 8'h01;
        for (int i = 1; i < 8; i++) begin
            cell_bool = ~occ;
            send_cmd(OP_INSERT, 8'd0, 8'(i), 8'(8'h10 + i), 8'd0, 8'd0);
            wait_rsp();
            tests++; if (lat != 5 || host.rsp_hit !== 1'b1 || host.rsp_handle !== 8'(i) || l_ah !== 8'(i)) begin
                fails++; $display("FAIL fill_%0d: got lat=%0d hit=%b handle=%0d ah=%0d want 5 1 %0d %0d",
                                  i, lat, host.rsp_hit, host.rsp_handle, l_ah, i, i); end
            finish_rsp();
            occ[i] = 1'b1;
        end
        cell_bool = ~occ;
        send_cmd(OP_INSERT, 8'd0, 8'd9, 8'h99, 8'd0, 8'd0);
        wait_rsp();
        tests++; if (lat != 3) begin fails++; $display("FAIL full_latency: got %0d want 3", lat); end
        tests++; if (sel_pack !== 32'h00000508) begin fails++; $display("FAIL full_selseq: got %h want 00000508", sel_pack); end
        tests++; if (host.rsp_hit !== 1'b0 || host.rsp_handle !== 8'd0) begin
            fails++; $display("FAIL full_rsp: got hit=%b handle=%0d want 0 0", host.rsp_hit, host.rsp_handle); end
        finish_rsp();
    endtask

    task automatic test_lookup();
        cell_bool = 8'b0010_0100; cell_context = '0; cell_result = '0;
        cell_context[2*W +: W] = 8'd1; cell_result[2*W +: W] = 8'hA2;
        cell_context[5*W +: W] = 8'd2; cell_result[5*W +: W] = 8'hB5;
        send_cmd(OP_LOOKUP, 8'd0, 8'd3, 8'd0, 8'h11, 8'd0);
        wait_rsp();
        tests++; if (lat != 3 || sel_pack !== 32'h00000108) begin
            fails++; $display("FAIL lookup_timing: got lat=%0d sel=%h want 3 00000108", lat, sel_pack); end
        tests++; if ({host.rsp_hit, host.rsp_handle, host.rsp_value, host.rsp_context} !== {1'b1, 8'd5, 8'hB5, 8'd2}) begin
            fails++; $display("FAIL lookup_maxrank: got hit=%b h=%0d v=%h c=%0d want 1 5 b5 2",
                              host.rsp_hit, host.rsp_handle, host.rsp_value, host.rsp_context); end
        tests++; if ({l_ii, l_gc, l_igc, l_iah} !== {8'd3, 8'h11, 1'b1, 1'b0}) begin
            fails++; $display("FAIL lookup_bcast: got ii=%0d gc=%h igc=%b iah=%b want 3 11 1 0", l_ii, l_gc, l_igc, l_iah); end
        finish_rsp();
        cell_bool = 8'b0100_0010; cell_context = '0; cell_result = '0;
        cell_context[1*W +: W] = 8'd3; cell_result[1*W +: W] = 8'hC1;
        cell_context[6*W +: W] = 8'd3; cell_result[6*W +: W] = 8'hC6;
        send_cmd(OP_LOOKUP, 8'd0, 8'd3, 8'd0, 8'h11, 8'd0);
        wait_rsp();
        tests++; if (host.rsp_handle !== 8'd1 || host.rsp_value !== 8'hC1) begin
            fails++; $display("FAIL lookup_tie: got h=%0d v=%h want 1 c1", host.rsp_handle, host.rsp_value); end
        finish_rsp();
    endtask

    task automatic test_encode();
        cell_bool = 8'h00;
        send_cmd(OP_ENCODE, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_rsp();
        tests++; if (host.rsp_hit !== 1'b0 || host.rsp_handle !== 8'd0 || l_qh !== 8'd9 || sel_pack !== 32'h00000208) begin
            fails++; $display("FAIL encode_miss: got hit=%b h=%0d qh=%0d sel=%h want 0 0 9 00000208",
                              host.rsp_hit, host.rsp_handle, l_qh, sel_pack); end
        finish_rsp();
        cell_bool = 8'b0000_0100; cell_result = '0; cell_context = '0;
        cell_result[2*W +: W] = 8'h77; cell_context[2*W +: W] = 8'h05;
        send_cmd(OP_ENCODE, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_rsp();
        tests++; if ({host.rsp_hit, host.rsp_handle, host.rsp_value, host.rsp_context} !== {1'b1, 8'd2, 8'h77, 8'h05}) begin
            fails++; $display("FAIL encode_hit: got hit=%b h=%0d v=%h c=%h want 1 2 77 05",
                              host.rsp_hit, host.rsp_handle, host.rsp_value, host.rsp_context); end
        finish_rsp();
        send_cmd(OP_ENRANK, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_rsp();
        tests++; if (sel_pack !== 32'h00000608 || host.rsp_hit !== 1'b1 || host.rsp_handle !== 8'd2) begin
            fails++; $display("FAIL enrank: got sel=%h hit=%b h=%0d want 00000608 1 2", sel_pack, host.rsp_hit, host.rsp_handle); end
        finish_rsp();
        cell_bool = 8'b1000_0000;
        send_cmd(OP_CONGRUE_DOWN, 8'd4, 8'd0, 8'd0, 8'h22, 8'd0);
        wait_rsp();
        tests++; if (sel_pack !== 32'h00000408 || host.rsp_hit !== 1'b1 || {l_qh, l_gc, l_igc} !== {8'd4, 8'h22, 1'b1}) begin
            fails++; $display("FAIL cdown: got sel=%h hit=%b qh=%0d gc=%h igc=%b want 00000408 1 4 22 1",
                              sel_pack, host.rsp_hit, l_qh, l_gc, l_igc); end
        finish_rsp();
    endtask

    task automatic test_hold();
        cell_bool = 8'b0010_0100; cell_context = '0; cell_result = '0;
        cell_context[2*W +: W] = 8'd1; cell_result[2*W +: W] = 8'hA2;
        cell_context[5*W +: W] = 8'd2; cell_result[5*W +: W] = 8'hB5;
        send_cmd(OP_LOOKUP, 8'd0, 8'd3, 8'd0, 8'h11, 8'd0);
        wait_rsp();
        cell_bool = 8'h00; cell_result = '1; cell_context = '1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            tests++; if ({host.rsp_valid, host.cmd_ready, host.rsp_handle, host.rsp_value, host.rsp_context} !==
                         {1'b1, 1'b0, 8'd5, 8'hB5, 8'd2}) begin
                fails++; $display("FAIL hold_%0d: got v=%b cr=%b h=%0d val=%h c=%0d want 1 0 5 b5 2", k,
                                  host.rsp_valid, host.cmd_ready, host.rsp_handle, host.rsp_value, host.rsp_context); end
        end
        finish_rsp();
        tests++; if (host.cmd_ready !== 1'b1 || host.rsp_valid !== 1'b0) begin
            fails++; $display("FAIL hold_release: got cr=%b v=%b want 1 0", host.cmd_ready, host.rsp_valid); end
    endtask

    task automatic test_illegal();
        send_cmd(3'd6, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
        wait_rsp();
        tests++; if (lat != 1 || sel_pack !== 32'd0) begin
            fails++; $display("FAIL illegal_timing: got lat=%0d sel=%h want 1 0", lat, sel_pack); end
        tests++; if ({host.rsp_hit, host.rsp_handle, host.rsp_value, host.rsp_context} !== 25'd0) begin
            fails++; $display("FAIL illegal_rsp: got hit=%b h=%0d v=%h c=%h want all 0",
                              host.rsp_hit, host.rsp_handle, host.rsp_value, host.rsp_context); end
        finish_rsp();
    endtask

    task automatic test_congrue_up();
        cell_bool = 8'b1111_0000;
        send_cmd(OP_CONGRUE_UP, 8'd0, 8'd0, 8'd0, 8'h33, 8'd7);
        wait_rsp();
        tests++; if (lat != 5 || sel_pack !== 32'h05080308) begin
            fails++; $display("FAIL cup_timing: got lat=%0d sel=%h want 5 05080308", lat, sel_pack); end
        tests++; if (host.rsp_hit !== 1'b1 || host.rsp_handle !== 8'd4) begin
            fails++; $display("FAIL cup_rsp: got hit=%b h=%0d want 1 4", host.rsp_hit, host.rsp_handle); end
        tests++; if ({l_ah, l_iah, l_gc, l_gr, l_igc, l_igr} !== {8'd4, 1'b1, 8'h33, 8'd7, 1'b1, 1'b1}) begin
            fails++; $display("FAIL cup_bcast: got ah=%0d iah=%b gc=%h gr=%0d igc=%b igr=%b want 4 1 33 7 1 1",
                              l_ah, l_iah, l_gc, l_gr, l_igc, l_igr); end
        finish_rsp();
    endtask

    task automatic test_reset_midop();
        cell_bool = 8'hFF;
        send_cmd(OP_CONGRUE_UP, 8'd0, 8'd0, 8'd0, 8'h44, 8'd2);
        repeat (2) @(posedge clk);
        #1;
        tests++; if (selector !== 8'd3) begin fails++; $display("FAIL midop_issue2: got sel=%0d want 3", selector); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        tests++; if ({selector, host.rsp_valid, host.cmd_ready, is_available_handle} !== {8'd8, 1'b0, 1'b1, 1'b0}) begin
            fails++; $display("FAIL midop_reset: got sel=%0d v=%b cr=%b iah=%b want 8 0 1 0",
                              selector, host.rsp_valid, host.cmd_ready, is_available_handle); end
        @(posedge clk); #1;
        tests++; if (host.rsp_valid !== 1'b0) begin fails++; $display("FAIL midop_norsp: got v=%b want 0", host.rsp_valid); end
        cell_bool = 8'b0000_1000;
        send_cmd(OP_ENCODE, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_rsp();
        tests++; if (host.rsp_hit !== 1'b1 || host.rsp_handle !== 8'd3) begin
            fails++; $display("FAIL midop_recover: got hit=%b h=%0d want 1 3", host.rsp_hit, host.rsp_handle); end
        finish_rsp();
    endtask

    initial begin
        host.cmd_valid = 1'b0; host.cmd_op = '0; host.cmd_handle = '0; host.cmd_index = '0;
        host.cmd_value = '0; host.cmd_code = '0; host.cmd_rank = '0; host.rsp_ready = 1'b0;
        cell_bool = '0; cell_result = '0; cell_context = '0;
        test_reset();
        test_insert_empty();
        test_fill();
        test_lookup();
        test_encode();
        test_hold();
        test_illegal();
        test_congrue_up();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
